wb_select_stage: RTL and testbench
==================================

Name: wb_select_stage

Overview:
- Registered, parametrised write-back select stage for the processor datapath.
- Chooses among NSRC result sources, such as memory read data, IO data and ALU result, and presents one registered write-back beat to the register file.
- Adds a valid/ready handshake and a wait state for slow IO sources, with a timeout.
- Sits between the memory/IO stage and the register file write port.

Parameters:
- DATA_W, 32, width of each source and of the write-back data.
- NSRC, 4, number of selectable sources; valid range 2..16.
- SEL_W, $clog2(NSRC), width of sel.
- IO_SRC, 1, index of the source that must wait for io_ready.
- IO_TIMEOUT, 255, maximum wait cycles in WAIT_IO; valid range 1..65535.
- REG_AW, 5, register-file address width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  stage can accept a request.
- sel  input  SEL_W  source index; codes >= NSRC select constant zero.
- src_data  input  NSRC*DATA_W  packed sources; source i occupies bits [i*DATA_W +: DATA_W].
- in_dest  input  REG_AW  destination register.
- in_we  input  1  register write requested.
- io_ready  input  1  src_data slot IO_SRC holds valid data this cycle.
- wb_valid  output  1  one-cycle write-back strobe.
- wb_data  output  DATA_W  selected data, registered.
- wb_dest  output  REG_AW  registered destination.
- wb_we  output  1  register write enable, qualified by wb_valid.
- io_timeout  output  1  sticky error flag; cleared only by reset.

Behaviour:
Reset values:
- State IDLE; in_ready 1.
- wb_valid 0, wb_data 0, wb_dest 0, wb_we 0.
- io_timeout 0; wait counter 0.

Acceptance:
- A request is accepted on any clock edge where in_valid & in_ready.
- in_ready = (state == IDLE).

State IDLE, on acceptance:
- sel != IO_SRC and sel < NSRC: capture src_data[sel], in_dest, in_we. wb_valid = 1 in the next cycle (latency 1).
- sel >= NSRC: capture wb_data = 0 and in_dest. wb_we = in_we. wb_valid = 1 next cycle.
- sel == IO_SRC and io_ready = 1 in the same cycle: capture as in the normal case (latency 1).
- sel == IO_SRC and io_ready = 0: latch in_dest and in_we internally, clear the counter, go to WAIT_IO. No output this cycle.

State WAIT_IO:
- in_ready = 0; the counter increments every cycle.
- io_ready = 1: capture src_data[IO_SRC] together with the latched dest/we. wb_valid = 1 next cycle; return to IDLE.
- Timeout (counter == IO_TIMEOUT-1 and io_ready = 0): wb_valid = 1 next cycle with wb_data = 0 and wb_we = 0. Set io_timeout; return to IDLE.
- If io_ready arrives in the timeout cycle, the data wins and no timeout is raised.

Output rules:
- wb_valid is a single-cycle pulse.
- wb_data and wb_dest hold their last values between pulses.
- wb_we is 0 whenever wb_valid is 0.
- Back-to-back non-IO requests give a wb_valid pulse every cycle (full throughput).

Reset mid-operation:
- Reset during WAIT_IO discards the pending request.
- Outputs return to their reset values on the next edge.

Optional Feature:
- WB_ZERO_GUARD_EN defined: when the captured dest == 0, wb_we is forced to 0 and wb_data to 0. wb_valid still pulses.
- Without the macro: dest 0 is written through unchanged; the register file is responsible for ignoring it.

Decomposition:
- Package wb_pkg holds:
  - state enum {IDLE, WAIT_IO};
  - default DATA_W and REG_AW constants;
  - SEL_ZERO helper function returning the zero-select decision.
- Sub-module wb_io_timer: the clearable, enabled wait counter with a terminal-count output, parametrised by IO_TIMEOUT.

Test Plan:
1. Reset, then sel=0, src0=0x1234_5678, in_dest=3, in_we=1 -> next cycle wb_valid=1, wb_data=0x1234_5678, wb_dest=3, wb_we=1; cycle after, wb_valid=0.
2. sel=2 then sel=0 on consecutive cycles, src2=0xA5A5_0001 -> wb_valid high two cycles, data 0xA5A5_0001 then src0.
3. sel=IO_SRC, io_ready=0 for 5 cycles, then 1 with src1=0xDEAD_BEEF -> in_ready=0 for 5 cycles; wb_data=0xDEAD_BEEF one cycle after io_ready; io_timeout=0.
4. IO_TIMEOUT=4, sel=IO_SRC, io_ready held 0 -> wb_valid after 4 wait cycles, wb_data=0, wb_we=0, io_timeout=1 and stays set.
5. sel=3 with NSRC=3 -> wb_data=0, wb_we=in_we. Also: reset asserted while in WAIT_IO -> no wb_valid, in_ready=1 next cycle.
6. WB_ZERO_GUARD_EN defined, in_dest=0, in_we=1, src0=0xFFFF_FFFF -> wb_valid=1, wb_we=0, wb_data=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back select stage.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_REG_AW = 5;

  typedef enum logic [0:0] {
    StIdle,
    StWaitIo
  } wb_state_e;

  // Out-of-range select codes pick constant zero instead of a source.
  function automatic logic sel_zero(input int unsigned sel, input int unsigned nsrc);
    return sel >= nsrc;
  endfunction

endpackage

// File: rtl/wb_io_timer.sv
// Clearable, enabled wait counter with a terminal-count flag at IO_TIMEOUT-1.
module wb_io_timer #(
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;

  logic [CntW-1:0] cnt_d, cnt_q;

  // Clear has priority so a fresh wait always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntW'(IO_TIMEOUT - 1));

endmodule

// File: rtl/wb_select_stage.sv
// Registered write-back select stage: picks one of NSRC sources, waits for io_ready on the
// IO source with a timeout, and emits a single-cycle write-back beat.
// Optional: define WB_ZERO_GUARD_EN to suppress writes (and zero data) to destination 0.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = WB_DATA_W,
  parameter int unsigned NSRC       = 4,
  parameter int unsigned SEL_W      = $clog2(NSRC),
  parameter int unsigned IO_SRC     = 1,
  parameter int unsigned IO_TIMEOUT = 255,
  parameter int unsigned REG_AW     = WB_REG_AW
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [REG_AW-1:0]      in_dest,
  input  logic                   in_we,
  input  logic                   io_ready,
  output logic                   wb_valid,
  output logic [DATA_W-1:0]      wb_data,
  output logic [REG_AW-1:0]      wb_dest,
  output logic                   wb_we,
  output logic                   io_timeout
);

  wb_state_e state_d, state_q;

  logic [REG_AW-1:0] pend_dest_d, pend_dest_q;
  logic              pend_we_d, pend_we_q;
  logic              wb_valid_d, wb_valid_q;
  logic [DATA_W-1:0] wb_data_d, wb_data_q;
  logic [REG_AW-1:0] wb_dest_d, wb_dest_q;
  logic              wb_we_d, wb_we_q;
  logic              io_timeout_d, io_timeout_q;

  logic              tmr_clr, tmr_en, tmr_tc;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] io_data;
  logic              sel_is_io;
  logic              accept;

  wb_io_timer #(
    .IO_TIMEOUT(IO_TIMEOUT)
  ) u_io_timer (
    .clk_i(clock),
    .rst_i(reset),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .tc_o (tmr_tc)
  );

  // Source mux; codes outside 0..NSRC-1 fall through to zero.
  always_comb begin
    sel_data = '0;
    if (!sel_zero(32'(sel), NSRC)) begin
      for (int i = 0; i < NSRC; i++) begin
        if (sel == SEL_W'(i)) begin
          sel_data = src_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign io_data   = src_data[IO_SRC*DATA_W +: DATA_W];
  assign sel_is_io = (sel == SEL_W'(IO_SRC));
  assign in_ready  = (state_q == StIdle);
  assign accept    = in_valid && in_ready;

  // Next-state and write-back beat formation.
  always_comb begin
    state_d      = state_q;
    pend_dest_d  = pend_dest_q;
    pend_we_d    = pend_we_q;
    wb_valid_d   = 1'b0;
    wb_data_d    = wb_data_q;
    wb_dest_d    = wb_dest_q;
    wb_we_d      = 1'b0;
    io_timeout_d = io_timeout_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (sel_is_io && !io_ready) begin
            pend_dest_d = in_dest;
            pend_we_d   = in_we;
            tmr_clr     = 1'b1;
            state_d     = StWaitIo;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = sel_data;
            wb_dest_d  = in_dest;
            wb_we_d    = in_we;
          end
        end
      end
      StWaitIo: begin
        tmr_en = 1'b1;
        // Data arriving in the terminal cycle beats the timeout.
        if (io_ready) begin
          wb_valid_d = 1'b1;
          wb_data_d  = io_data;
          wb_dest_d  = pend_dest_q;
          wb_we_d    = pend_we_q;
          state_d    = StIdle;
        end else if (tmr_tc) begin
          wb_valid_d   = 1'b1;
          wb_data_d    = '0;
          wb_dest_d    = pend_dest_q;
          wb_we_d      = 1'b0;
          io_timeout_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef WB_ZERO_GUARD_EN
    if (wb_valid_d && (wb_dest_d == '0)) begin
      wb_we_d   = 1'b0;
      wb_data_d = '0;
    end
`endif
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_dest_q  <= '0;
      pend_we_q    <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_dest_q    <= '0;
      wb_we_q      <= 1'b0;
      io_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_dest_q  <= pend_dest_d;
      pend_we_q    <= pend_we_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_dest_q    <= wb_dest_d;
      wb_we_q      <= wb_we_d;
      io_timeout_q <= io_timeout_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_dest    = wb_dest_q;
  assign wb_we      = wb_we_q;
  assign io_timeout = io_timeout_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage (NSRC=3 so sel=3 exercises the zero select).
module tb_wb_select_stage;

  localparam int unsigned DW  = 32;
  localparam int unsigned NS  = 3;
  localparam int unsigned SW  = 2;
  localparam int unsigned IOS = 1;
  localparam int unsigned TO  = 8;
  localparam int unsigned AW  = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [SW-1:0]     sel;
  logic [NS*DW-1:0]  src_data;
  logic [DW-1:0]     src [NS];
  logic [AW-1:0]     in_dest;
  logic              in_we;
  logic              io_ready;
  logic              wb_valid;
  logic [DW-1:0]     wb_data;
  logic [AW-1:0]     wb_dest;
  logic              wb_we;
  logic              io_timeout;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] dest;
    logic          we;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  wb_exp_t mon_e;
  int      n_checks = 0;
  int      n_fail   = 0;

  assign src_data = {src[2], src[1], src[0]};

  always #5 clock = ~clock;

  wb_select_stage #(
    .DATA_W    (DW),
    .NSRC      (NS),
    .SEL_W     (SW),
    .IO_SRC    (IOS),
    .IO_TIMEOUT(TO),
    .REG_AW    (AW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .src_data  (src_data),
    .in_dest   (in_dest),
    .in_we     (in_we),
    .io_ready  (io_ready),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .wb_dest   (wb_dest),
    .wb_we     (wb_we),
    .io_timeout(io_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic wb_exp_t model(input logic [DW-1:0] data, input logic [AW-1:0] dest,
                                    input logic we);
    wb_exp_t e;
    e.data = data;
    e.dest = dest;
    e.we   = we;
`ifdef WB_ZERO_GUARD_EN
    if (dest == '0) begin
      e.data = '0;
      e.we   = 1'b0;
    end
`endif
    return e;
  endfunction

  function automatic logic [DW-1:0] src_of(input logic [SW-1:0] s);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < NS; i++) begin
      if (int'(s) == i) d = src[i];
    end
    return d;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one request for one edge; immediate captures are scored and latency-checked.
  task automatic issue(input logic [SW-1:0] s, input logic [AW-1:0] d, input logic w,
                       input logic ior);
    logic immediate;
    immediate = (s != SW'(IOS)) || ior;
    in_valid  = 1'b1;
    sel       = s;
    in_dest   = d;
    in_we     = w;
    io_ready  = ior;
    check_eq("accept_ready", in_ready, 1'b1);
    if (immediate) exp_q.push_back(model(src_of(s), d, w));
    step();
    in_valid = 1'b0;
    io_ready = 1'b0;
    if (immediate) check_eq("latency1_valid", wb_valid, 1'b1);
  endtask

  // Output monitor: every pulse is matched against the scoreboard head.
  always @(negedge clock) begin
    if (!reset) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("wb_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("wb_data", wb_data, mon_e.data);
          check_eq("wb_dest", 32'(wb_dest), 32'(mon_e.dest));
          check_eq("wb_we", 32'(wb_we), 32'(mon_e.we));
        end
      end else begin
        check_eq("wb_we_idle", 32'(wb_we), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [SW-1:0] s;
    reset    = 1'b1;
    in_valid = 1'b0;
    sel      = '0;
    in_dest  = '0;
    in_we    = 1'b0;
    io_ready = 1'b0;
    for (int i = 0; i < NS; i++) src[i] = '0;
    repeat (3) step();
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_wb_valid", wb_valid, 1'b0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    check_eq("rst_wb_dest", 32'(wb_dest), 32'd0);
    check_eq("rst_wb_we", wb_we, 1'b0);
    check_eq("rst_io_timeout", io_timeout, 1'b0);
    reset = 1'b0;
    step();

    // Plain capture, one-cycle pulse.
    src[0] = 32'h1234_5678;
    issue(2'd0, 5'd3, 1'b1, 1'b0);
    step();
    check_eq("t1_pulse_end", wb_valid, 1'b0);
    check_eq("t1_data_hold", wb_data, 32'h1234_5678);

    // Back-to-back full throughput.
    src[2] = 32'hA5A5_0001;
    issue(2'd2, 5'd4, 1'b1, 1'b0);
    issue(2'd0, 5'd5, 1'b1, 1'b0);
    step();

    // Randomised non-IO stream.
    for (int k = 0; k < 8; k++) begin
      s = SW'($urandom_range(0, 3));
      if (s == SW'(IOS)) s = 2'd0;
      for (int i = 0; i < NS; i++) src[i] = $urandom;
      issue(s, AW'($urandom_range(1, 31)), 1'($urandom_range(0, 1)), 1'b0);
    end
    step();

    // IO wait resolved by io_ready.
    issue(2'(IOS), 5'd6, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_wait_ready", in_ready, 1'b0);
      step();
    end
    src[1]   = 32'hDEAD_BEEF;
    io_ready = 1'b1;
    exp_q.push_back(model(src[1], 5'd6, 1'b1));
    check_eq("t3_wait_ready", in_ready, 1'b0);
    step();
    io_ready = 1'b0;
    check_eq("t3_valid", wb_valid, 1'b1);
    check_eq("t3_in_ready", in_ready, 1'b1);
    check_eq("t3_no_timeout", io_timeout, 1'b0);

    // io_ready arrives in the terminal cycle: data wins.
    issue(2'(IOS), 5'd8, 1'b1, 1'b0);
    repeat (TO - 1) step();
    src[1]   = 32'hCAFE_F00D;
    io_ready = 1'b1;
    exp_q.push_back(model(src[1], 5'd8, 1'b1));
    step();
    io_ready = 1'b0;
    check_eq("race_valid", wb_valid, 1'b1);
    check_eq("race_no_timeout", io_timeout, 1'b0);

    // Out-of-range select gives zero data, we passes through.
    issue(2'd3, 5'd9, 1'b1, 1'b0);
    issue(2'd3, 5'd10, 1'b0, 1'b0);

    // Destination 0.
    src[0] = 32'hFFFF_FFFF;
    issue(2'd0, 5'd0, 1'b1, 1'b0);
    step();

    // Timeout.
    issue(2'(IOS), 5'd7, 1'b1, 1'b0);
    exp_q.push_back(model('0, 5'd7, 1'b0));
    n = 0;
    while (!wb_valid && n < 3 * TO) begin
      step();
      n++;
    end
    check_eq("t4_wait_cycles", n, TO);
    check_eq("t4_timeout_set", io_timeout, 1'b1);
    check_eq("t4_in_ready", in_ready, 1'b1);
    issue(2'd2, 5'd12, 1'b1, 1'b0);
    step();
    check_eq("t4_timeout_sticky", io_timeout, 1'b1);

    // Reset while waiting discards the request.
    issue(2'(IOS), 5'd11, 1'b1, 1'b0);
    step();
    check_eq("t5_waiting", in_ready, 1'b0);
    reset = 1'b1;
    step();
    check_eq("t5_rst_in_ready", in_ready, 1'b1);
    check_eq("t5_rst_valid", wb_valid, 1'b0);
    check_eq("t5_rst_timeout", io_timeout, 1'b0);
    check_eq("t5_rst_data", wb_data, 32'd0);
    check_eq("t5_rst_dest", 32'(wb_dest), 32'd0);
    reset = 1'b0;
    repeat (2) begin
      step();
      check_eq("t5_no_late_valid", wb_valid, 1'b0);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step();
      n++;
    end
    check_eq("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
